// File: rtl/serial_parity_checker_if.sv
// Serial parity link receive-side bundle: qualified bit stream in, word/status out.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              DIN;
    logic              DVALID;
    logic              FSTART;
    logic [DATA_W-1:0] DOUT;
    logic              PERR;
    logic              DONE;
    logic              ABORT;

    modport master (
        output DIN, DVALID, FSTART,
        input  DOUT, PERR, DONE, ABORT
    );

    modport slave (
        input  DIN, DVALID, FSTART,
        output DOUT, PERR, DONE, ABORT
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames of DATA_W data bits plus one parity bit and flags mismatches.
//   state | meaning
//   IDLE  | waiting for a frame-start bit
//   DATA  | collecting data bits 1..DATA_W-1
//   PAR   | next valid bit is the parity bit
module serial_parity_checker #(
    parameter int DATA_W  = 8,
    parameter bit ODD_PAR = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST,
    serial_parity_checker_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par, w_par_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;
    logic              r_perr, w_perr_nxt;
    logic              r_done, w_done_nxt;
    logic              r_abort, w_abort_nxt;
    logic              w_start;
    logic [DATA_W-1:0] w_bit0;

    assign w_start = bus.DVALID & bus.FSTART;
    assign w_bit0  = {{(DATA_W-1){1'b0}}, bus.DIN};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_dout  <= '0;
            r_perr  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_dout  <= w_dout_nxt;
            r_perr  <= w_perr_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_dout_nxt  = r_dout;
        w_perr_nxt  = r_perr;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;

        // A frame start restarts from any state; only mid-frame does it count as an abort.
        if (w_start) begin
            w_abort_nxt = (r_state != IDLE);
            w_shift_nxt = w_bit0;
            w_par_nxt   = bus.DIN;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (DATA_W == 1) ? PAR : DATA;
        end else if (bus.DVALID) begin
            unique case (r_state)
                IDLE: ;
                DATA: begin
                    w_shift_nxt = r_shift | (w_bit0 << r_cnt);
                    w_par_nxt   = r_par ^ bus.DIN;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1))
                        w_state_nxt = PAR;
                end
                PAR: begin
                    w_dout_nxt  = r_shift;
                    w_perr_nxt  = bus.DIN ^ r_par ^ ODD_PAR;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.DOUT  = r_dout;
    assign bus.PERR  = r_perr;
    assign bus.DONE  = r_done;
    assign bus.ABORT = r_abort;
endmodule
